// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, grant index
// width and the arbiter FSM state encoding.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_DONE,
    ARB_GAP
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker. The search starts one past the
// previously granted index and wraps, so the last winner has lowest priority.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_idx_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  // Walk the requests from last_idx+1 around to last_idx and take the first set bit
  always_comb begin
    int cand;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_idx_i) + k) % N;
      if (!valid_o && req_i[cand[SW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART_TX serialiser between N_REQ byte
// producers: grant, one-cycle DV pulse, wait for TX Done (with a watchdog),
// then an optional inter-frame gap before the next grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic                    i_Clock,
  input  logic                    i_Rst_L,
  input  logic [N_REQ-1:0]        i_Req,
  input  logic [BYTE_W*N_REQ-1:0] i_Req_Byte,
  output logic [N_REQ-1:0]        o_Ack,
  output logic [N_REQ-1:0]        o_Done,
  output logic [IDX_W-1:0]        o_Grant_Idx,
  output logic                    o_Busy,
  output logic                    o_Err,
  output logic                    o_TX_DV,
  output logic [BYTE_W-1:0]       o_TX_Byte,
  input  logic                    i_TX_Active,
  input  logic                    i_TX_Done
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

  // The counter is cleared in ISSUE and counts up once per WAIT_DONE cycle. Its
  // incremented value reaches TIMEOUT_CLKS-1 while the registered value is
  // TIMEOUT_CLKS-2, which makes o_Err appear exactly TIMEOUT_CLKS clocks after DV.
  localparam logic [TW-1:0]    TO_LAST    = TW'(TIMEOUT_CLKS - 2);
  localparam logic [GW-1:0]    GAP_LAST   = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_RESET  = IDX_W'(N_REQ - 1);
  localparam arb_state_e       POST_FRAME = (GAP_CLKS > 0) ? ARB_GAP : ARB_IDLE;

  arb_state_e          state_q, state_d;
  logic [BYTE_W-1:0]   txByte_q, txByte_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [TW-1:0]       toCnt_q, toCnt_d;
  logic [GW-1:0]       gapCnt_q, gapCnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    arbIdx;
  logic                arbValid;
  logic [BYTE_W-1:0]   reqByteSel;
  logic [N_REQ-1:0]    grantOneHot;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req_i      (i_Req),
    .last_idx_i (grant_q),
    .idx_o      (arbIdx),
    .valid_o    (arbValid)
  );

  // Select the byte belonging to the current arbitration winner
  always_comb begin
    reqByteSel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arbIdx == IDX_W'(k)) begin
        reqByteSel = i_Req_Byte[k*BYTE_W +: BYTE_W];
      end
    end
  end

  assign grantOneHot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

  assign o_TX_DV     = (state_q == ARB_ISSUE);
  assign o_Ack       = o_TX_DV ? grantOneHot : '0;
  assign o_Done      = done_q;
  assign o_Err       = err_q;
  assign o_Busy      = busy_q;
  assign o_Grant_Idx = grant_q;
  assign o_TX_Byte   = txByte_q;

  // Next-state logic: grant in IDLE, pulse DV in ISSUE, watch Done/watchdog, then gap
  always_comb begin
    state_d  = state_q;
    txByte_d = txByte_q;
    grant_d  = grant_q;
    toCnt_d  = toCnt_q;
    gapCnt_d = gapCnt_q;
    done_d   = '0;
    err_d    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (arbValid && !i_TX_Active) begin
          txByte_d = reqByteSel;
          grant_d  = arbIdx;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        toCnt_d = '0;
        state_d = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        if (i_TX_Done) begin
          done_d   = grantOneHot;
          gapCnt_d = '0;
          state_d  = POST_FRAME;
        end else if (toCnt_q >= TO_LAST) begin
          err_d    = 1'b1;
          gapCnt_d = '0;
          state_d  = POST_FRAME;
        end else if (toCnt_q != {TW{1'b1}}) begin
          toCnt_d = toCnt_q + 1'b1;
        end
      end
      ARB_GAP: begin
        if (gapCnt_q >= GAP_LAST) begin
          state_d = ARB_IDLE;
        end else if (gapCnt_q != {GW{1'b1}}) begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  // State and datapath registers, cleared immediately on reset
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ARB_IDLE;
      txByte_q <= '0;
      grant_q  <= IDX_RESET;
      busy_q   <= 1'b0;
      toCnt_q  <= '0;
      gapCnt_q <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      txByte_q <= txByte_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      toCnt_q  <= toCnt_d;
      gapCnt_q <= gapCnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple UART_TX timing model.
// Expected grants are derived from the round-robin rule and queued when a
// round of requests is issued; a monitor pops them on every DV pulse.
module tb_uart_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int GAP_CLKS     = 5;
  localparam int TIMEOUT_CLKS = 64;
  localparam int CLKS_PER_BIT = 4;
  localparam int WAIT_LIMIT   = 400;

  typedef struct {
    int         idx;
    logic [7:0] data;
    bit         first;
    bit         expErr;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 rstL;
  logic [N_REQ-1:0]     req;
  logic [8*N_REQ-1:0]   reqByte;
  logic [N_REQ-1:0]     ack;
  logic [N_REQ-1:0]     done;
  logic [2:0]           grantIdx;
  logic                 busy;
  logic                 err;
  logic                 txDv;
  logic [7:0]           txByte;
  logic                 txActive;
  logic                 txDone;

  logic                 uartActive;
  logic                 uartDoneRaw;
  int                   uartCnt;
  bit                   killDone;

  exp_t                 expQ[$];
  int                   modelPtr;
  int                   nCompared   = 0;
  int                   nMismatched = 0;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .GAP_CLKS     (GAP_CLKS),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .i_Clock     (clock),
    .i_Rst_L     (rstL),
    .i_Req       (req),
    .i_Req_Byte  (reqByte),
    .o_Ack       (ack),
    .o_Done      (done),
    .o_Grant_Idx (grantIdx),
    .o_Busy      (busy),
    .o_Err       (err),
    .o_TX_DV     (txDv),
    .o_TX_Byte   (txByte),
    .i_TX_Active (txActive),
    .i_TX_Done   (txDone)
  );

  always #5 clock = ~clock;

  // UART_TX stand-in: busy for one 10-bit frame after DV, then a one-cycle Done
  always @(posedge clock or negedge rstL) begin
    if (!rstL) begin
      uartActive  <= 1'b0;
      uartDoneRaw <= 1'b0;
      uartCnt     <= 0;
    end else begin
      uartDoneRaw <= 1'b0;
      if (!uartActive) begin
        if (txDv) begin
          uartActive <= 1'b1;
          uartCnt    <= 0;
        end
      end else if (uartCnt == 10*CLKS_PER_BIT - 1) begin
        uartActive  <= 1'b0;
        uartDoneRaw <= 1'b1;
      end else begin
        uartCnt <= uartCnt + 1;
      end
    end
  end

  assign txActive = uartActive;
  assign txDone   = uartDoneRaw & ~killDone;

  function automatic logic [N_REQ-1:0] onehot(input int i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: serve pending sources in circular order starting after the last grant
  task automatic predict(input logic [N_REQ-1:0] mask, input logic [8*N_REQ-1:0] bytes,
                         input int n, input bit expErr);
    int  cand;
    int  pushed;
    bit  first;
    exp_t e;
    cand   = modelPtr;
    pushed = 0;
    first  = 1'b1;
    while (pushed < n) begin
      cand = (cand + 1) % N_REQ;
      if (mask[cand]) begin
        e.idx    = cand;
        e.data   = bytes[cand*8 +: 8];
        e.first  = first;
        e.expErr = expErr;
        expQ.push_back(e);
        first    = 1'b0;
        pushed++;
        modelPtr = cand;
      end
    end
  endtask

  // Raise a set of requests together, drop each on its Ack (or all at the end when held)
  task automatic applyStimulus(input logic [N_REQ-1:0] mask, input logic [8*N_REQ-1:0] bytes,
                               input int n, input bit hold, input bit kill, input bit waitIdle);
    int got;
    int w;
    killDone = kill;
    predict(mask, bytes, n, kill);
    reqByte = bytes;
    req     = mask;
    got     = 0;
    while (got < n) begin
      w = 0;
      do begin
        @(posedge clock); #1;
        w++;
      end while (!(|ack) && w < WAIT_LIMIT);
      if (!(|ack)) begin
        checkOutput("ack_timeout", 32'(|ack), 32'd1);
        req      = '0;
        killDone = 1'b0;
        return;
      end
      got++;
      if (!hold) req = req & ~ack;
      else if (got == n) req = '0;
    end
    if (waitIdle) begin
      w = 0;
      while (busy && w < WAIT_LIMIT) begin
        @(posedge clock); #1;
        w++;
      end
      if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
    end
    killDone = 1'b0;
  endtask

  // Monitor: compares every DV, Done and Err pulse against the scoreboard
  initial begin
    int   cyc;
    int   curIdx;
    int   relCyc;
    int   errDue;
    bit   prevDone;
    exp_t e;
    cyc      = 0;
    curIdx   = 0;
    relCyc   = -1000;
    errDue   = -1;
    prevDone = 1'b0;
    forever begin
      @(posedge clock); #1;
      cyc++;
      if (!rstL) begin
        prevDone = 1'b0;
        errDue   = -1;
        continue;
      end
      if (prevDone) checkOutput("done_pulse", 32'(done), 32'(onehot(curIdx)));
      else if (done != '0) checkOutput("stray_done", 32'(done), 32'd0);
      if (cyc == errDue) begin
        checkOutput("err_pulse", 32'(err), 32'd1);
        checkOutput("no_done_on_err", 32'(done), 32'd0);
        errDue = -1;
      end else if (err) begin
        checkOutput("stray_err", 32'(err), 32'd0);
      end
      if (done != '0 || err) relCyc = cyc;
      if (txDv) begin
        checkOutput("dv_expected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("ack_onehot", 32'(ack), 32'(onehot(e.idx)));
          checkOutput("tx_byte", 32'(txByte), 32'(e.data));
          checkOutput("grant_idx", 32'(grantIdx), 32'(e.idx));
          checkOutput("busy_on_dv", 32'(busy), 32'd1);
          checkOutput("dv_while_active", 32'(txActive), 32'd0);
          if (!e.first) checkOutput("grant_spacing", 32'(cyc - relCyc), 32'(GAP_CLKS + 1));
          curIdx = e.idx;
          if (e.expErr) errDue = cyc + TIMEOUT_CLKS;
        end
      end
      prevDone = txDone;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_watchdog: simulation did not finish");
    $fatal(1, "[TB] stopping");
  end

  initial begin
    logic [N_REQ-1:0]   mask;
    logic [8*N_REQ-1:0] bytes;
    bit                 kill;
    rstL     = 1'b0;
    req      = '0;
    reqByte  = '0;
    killDone = 1'b0;
    modelPtr = N_REQ - 1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_grant", 32'(grantIdx), 32'(N_REQ - 1));
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_dv", 32'(txDv), 32'd0);
    checkOutput("reset_byte", 32'(txByte), 32'd0);
    #4 rstL = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    $display("[TB] contention, all four held");
    applyStimulus(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 5, 1'b1, 1'b0, 1'b1);

    $display("[TB] single request");
    applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'hA5}, 1, 1'b0, 1'b0, 1'b1);

    $display("[TB] rotation");
    applyStimulus(4'b0100, {8'h0D, 8'h0C, 8'h0B, 8'h0A}, 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0101, {8'h1D, 8'h1C, 8'h1B, 8'h1A}, 2, 1'b0, 1'b0, 1'b1);

    $display("[TB] watchdog timeout");
    applyStimulus(4'b0011, {8'h00, 8'h00, 8'h5A, 8'hC3}, 2, 1'b0, 1'b1, 1'b1);

    $display("[TB] random rounds");
    for (int r = 0; r < 8; r++) begin
      mask  = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      bytes = {$urandom()};
      kill  = ($urandom_range(0, 3) == 0);
      applyStimulus(mask, bytes, $countones(mask), 1'b0, kill, 1'b1);
    end

    $display("[TB] reset mid-frame");
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'h77, 8'h00}, 1, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clock);
    #3 rstL = 1'b0;
    #1;
    checkOutput("midreset_dv", 32'(txDv), 32'd0);
    checkOutput("midreset_ack", 32'(ack), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_err", 32'(err), 32'd0);
    checkOutput("midreset_byte", 32'(txByte), 32'd0);
    checkOutput("midreset_grant", 32'(grantIdx), 32'(N_REQ - 1));
    modelPtr = N_REQ - 1;
    #3 rstL = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    applyStimulus(4'b1111, {8'hD4, 8'hC3, 8'hB2, 8'hA1}, 4, 1'b0, 1'b0, 1'b1);

    repeat (5) @(posedge clock);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
